// File: rtl/ita_step_sequencer.sv
// ita_step_sequencer: walks one ITA layer invocation through its compute steps,
// heads and tiles, and presents each (step, head, tile) descriptor over a
// valid/ready handshake. The layer type, head count and tile counts are
// captured when a sequence starts.
module ita_step_sequencer #(
  parameter  int unsigned H         = 4,
  parameter  int unsigned TileWidth = 32,
  localparam int unsigned HeadCntW  = (H + 1 > 1) ? $clog2(H + 1) : 1,
  localparam int unsigned HeadW     = (H > 1) ? $clog2(H) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic                 clear_i,
  input  logic                 layer_i,
  input  logic [HeadCntW-1:0]  n_heads_i,
  input  logic [TileWidth-1:0] lin_tiles_i,
  input  logic [TileWidth-1:0] attn_tiles_i,
  output logic                 tile_valid_o,
  input  logic                 tile_ready_i,
  output logic [2:0]           step_o,
  output logic [HeadW-1:0]     head_o,
  output logic [TileWidth-1:0] tile_o,
  output logic [2:0]           requant_idx_o,
  output logic                 last_tile_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 cfg_err_o
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef enum logic [2:0] {
    STEP_IDLE = 3'd0,
    STEP_Q    = 3'd1,
    STEP_K    = 3'd2,
    STEP_V    = 3'd3,
    STEP_QK   = 3'd4,
    STEP_AV   = 3'd5,
    STEP_OW   = 3'd6,
    STEP_FF   = 3'd7
  } step_e;

  typedef enum logic {
    LAYER_ATTN = 1'b0,
    LAYER_FF   = 1'b1
  } layer_e;

  // A start is legal when every count the chosen layer uses is nonzero and
  // the head count fits the instantiated maximum.
  function automatic logic cfg_legal(
    input logic                 layer,
    input logic [HeadCntW-1:0]  n_heads,
    input logic [TileWidth-1:0] lin_tiles,
    input logic [TileWidth-1:0] attn_tiles
  );
    logic ok;
    ok = (lin_tiles != '0);
    if (layer == LAYER_ATTN) begin
      ok = ok && (attn_tiles != '0) && (n_heads != '0) &&
           (n_heads <= HeadCntW'(H));
    end
    return ok;
  endfunction

  // Attention step order within one head; OW wraps back to Q on the next head.
  function automatic step_e next_attn_step(input step_e s);
    step_e n;
    case (s)
      STEP_Q:  n = STEP_K;
      STEP_K:  n = STEP_V;
      STEP_V:  n = STEP_QK;
      STEP_QK: n = STEP_AV;
      STEP_AV: n = STEP_OW;
      default: n = STEP_Q;
    endcase
    return n;
  endfunction

  state_e               state_q;
  step_e                step_q;
  layer_e               layer_q;
  logic [TileWidth-1:0] lin_q;
  logic [TileWidth-1:0] attn_q;
  logic [HeadCntW-1:0]  n_heads_q;
  logic [HeadW-1:0]     head_q;
  logic [TileWidth-1:0] tile_q;
  logic [2:0]           requant_q;
  logic                 valid_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 cfg_err_q;

  logic [TileWidth-1:0] step_cnt;
  logic                 at_last_tile;
  logic                 at_last_head;
  logic                 handshake;
  logic                 seq_end;
  logic                 start_ok;
  logic                 start_bad;
  logic                 legal;

  // Decode of the registered state: current step length, boundaries, start checks.
  always_comb begin
    step_cnt     = ((step_q == STEP_QK) || (step_q == STEP_AV)) ? attn_q : lin_q;
    at_last_tile = (tile_q == step_cnt - TileWidth'(1));
    at_last_head = (HeadCntW'(head_q) == n_heads_q - HeadCntW'(1));
    handshake    = valid_q & tile_ready_i;
    // The final descriptor is the last tile of FF pass 2, or of OW on the last head.
    seq_end      = handshake & at_last_tile &
                   (((layer_q == LAYER_FF) && (requant_q == 3'd1)) ||
                    ((layer_q == LAYER_ATTN) && (step_q == STEP_OW) && at_last_head));
    legal        = cfg_legal(layer_i, n_heads_i, lin_tiles_i, attn_tiles_i);
    // A soft abort outranks a start arriving in the same cycle.
    start_ok     = (state_q == IDLE) & start_i & ~clear_i & legal;
    start_bad    = (state_q == IDLE) & start_i & ~clear_i & ~legal;
  end

  // Configuration capture at start; held untouched for the whole sequence.
  always_ff @(posedge clk_i) begin
    if (start_ok) begin
      layer_q   <= layer_e'(layer_i);
      lin_q     <= lin_tiles_i;
      attn_q    <= attn_tiles_i;
      n_heads_q <= n_heads_i;
    end
  end

  // Sequencer FSM: IDLE waits for a legal start, RUN advances on each handshake.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      step_q    <= STEP_IDLE;
      head_q    <= '0;
      tile_q    <= '0;
      requant_q <= 3'd0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_ok) begin
            state_q   <= RUN;
            valid_q   <= 1'b1;
            busy_q    <= 1'b1;
            step_q    <= layer_i ? STEP_FF : STEP_Q;
            head_q    <= '0;
            tile_q    <= '0;
            requant_q <= 3'd0;
          end else if (start_bad) begin
            cfg_err_q <= 1'b1;
          end
        end
        RUN: begin
          if (clear_i || seq_end) begin
            state_q   <= IDLE;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            step_q    <= STEP_IDLE;
            head_q    <= '0;
            tile_q    <= '0;
            requant_q <= 3'd0;
            done_q    <= ~clear_i;
          end else if (handshake) begin
            if (!at_last_tile) begin
              tile_q <= tile_q + TileWidth'(1);
            end else begin
              tile_q <= '0;
              if (layer_q == LAYER_FF) begin
                requant_q <= 3'd1;
              end else if (step_q == STEP_OW) begin
                head_q    <= head_q + HeadW'(1);
                step_q    <= STEP_Q;
                requant_q <= 3'd0;
              end else begin
                step_q    <= next_attn_step(step_q);
                requant_q <= requant_q + 3'd1;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tile_valid_o  = valid_q;
  assign step_o        = step_q;
  assign head_o        = head_q;
  assign tile_o        = tile_q;
  assign requant_idx_o = requant_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign cfg_err_o     = cfg_err_q;
  // Only meaningful while a descriptor is presented; low in IDLE.
  assign last_tile_o   = valid_q & at_last_tile;

endmodule

// File: tb/tb_ita_step_sequencer.sv
// Testbench for ita_step_sequencer: a scoreboard of expected descriptors is
// filled by the stimulus; a monitor pops and compares on every handshake and
// checks that descriptors hold steady under backpressure.
module tb_ita_step_sequencer;

  localparam int H  = 4;
  localparam int TW = 32;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          start_i = 1'b0;
  logic          clear_i = 1'b0;
  logic          layer_i = 1'b0;
  logic [2:0]    n_heads_i = 3'd1;
  logic [TW-1:0] lin_tiles_i = 1;
  logic [TW-1:0] attn_tiles_i = 1;
  logic          tile_valid_o;
  logic          tile_ready_i = 1'b0;
  logic [2:0]    step_o;
  logic [1:0]    head_o;
  logic [TW-1:0] tile_o;
  logic [2:0]    requant_idx_o;
  logic          last_tile_o;
  logic          busy_o;
  logic          done_o;
  logic          cfg_err_o;

  ita_step_sequencer #(.H(H), .TileWidth(TW)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .start_i       (start_i),
    .clear_i       (clear_i),
    .layer_i       (layer_i),
    .n_heads_i     (n_heads_i),
    .lin_tiles_i   (lin_tiles_i),
    .attn_tiles_i  (attn_tiles_i),
    .tile_valid_o  (tile_valid_o),
    .tile_ready_i  (tile_ready_i),
    .step_o        (step_o),
    .head_o        (head_o),
    .tile_o        (tile_o),
    .requant_idx_o (requant_idx_o),
    .last_tile_o   (last_tile_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .cfg_err_o     (cfg_err_o)
  );

  always #5 clk_i = ~clk_i;

  // Descriptor packing: {step, head, tile, requant_idx, last}
  typedef logic [40:0] desc_t;

  desc_t exp_q[$];
  int    errors   = 0;
  int    checks   = 0;
  int    done_cnt = 0;

  function automatic desc_t mk(input int s, input int h, input int t, input int r, input int l);
    return {3'(s), 2'(h), 32'(t), 3'(r), 1'(l)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected attention sequence: per head Q,K,V,QK,AV,OW, requant = step-1.
  task automatic push_attn(input int nh, input int lin, input int attn);
    for (int h = 0; h < nh; h++)
      for (int s = 1; s <= 6; s++) begin
        int cnt;
        cnt = (s == 4 || s == 5) ? attn : lin;
        for (int t = 0; t < cnt; t++)
          exp_q.push_back(mk(s, h, t, s - 1, (t == cnt - 1) ? 1 : 0));
      end
  endtask

  // Expected feedforward sequence: two FF passes with requant 0 then 1.
  task automatic push_ff(input int lin);
    for (int p = 0; p < 2; p++)
      for (int t = 0; t < lin; t++)
        exp_q.push_back(mk(7, 0, t, p, (t == lin - 1) ? 1 : 0));
  endtask

  desc_t cur_desc;
  desc_t held_desc;
  bit    hold_v = 1'b0;

  // Monitor: compare every handshake against the scoreboard, check stability under stall.
  always @(negedge clk_i) begin
    cur_desc = {step_o, head_o, tile_o, requant_idx_o, last_tile_o};
    if (done_o) done_cnt++;
    if (hold_v) begin
      check("stall_valid", 64'(tile_valid_o), 64'd1);
      check("stall_desc", 64'(cur_desc), 64'(held_desc));
    end
    hold_v    = tile_valid_o && !tile_ready_i && !clear_i && rst_ni;
    held_desc = cur_desc;
    if (tile_valid_o && tile_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_desc: got %0h expected none at %0t", cur_desc, $time);
      end else begin
        check("desc", 64'(cur_desc), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic wait_done(input int budget, input bit toggle, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk_i);
      #1;
      if (toggle) tile_ready_i = ~tile_ready_i;
      @(negedge clk_i);
      if (done_o) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
  endtask

  // Full run: start, check first-cycle latency, wait for done, check the idle return.
  task automatic run_seq(input string name, input bit toggle);
    bit seen;
    int d0;
    d0 = done_cnt;
    pulse_start();
    @(negedge clk_i);
    check({name, "_busy_t1"}, 64'(busy_o), 64'd1);
    check({name, "_valid_t1"}, 64'(tile_valid_o), 64'd1);
    wait_done(200, toggle, seen);
    check({name, "_done_seen"}, 64'(seen), 64'd1);
    check({name, "_valid_end"}, 64'(tile_valid_o), 64'd0);
    check({name, "_busy_end"}, 64'(busy_o), 64'd0);
    check({name, "_step_end"}, 64'(step_o), 64'd0);
    check({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    @(negedge clk_i);
    check({name, "_done_once"}, 64'(done_cnt - d0), 64'd1);
    check({name, "_done_low"}, 64'(done_o), 64'd0);
    exp_q.delete();
  endtask

  task automatic cfg_reject(input string name);
    pulse_start();
    @(negedge clk_i);
    check({name, "_err"}, 64'(cfg_err_o), 64'd1);
    check({name, "_busy"}, 64'(busy_o), 64'd0);
    check({name, "_valid"}, 64'(tile_valid_o), 64'd0);
    @(negedge clk_i);
    check({name, "_err_pulse"}, 64'(cfg_err_o), 64'd0);
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    bit seen;
    int d0;

    // Reset held for two cycles
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_valid", 64'(tile_valid_o), 64'd0);
    check("rst_step", 64'(step_o), 64'd0);
    check("rst_head", 64'(head_o), 64'd0);
    check("rst_tile", 64'(tile_o), 64'd0);
    check("rst_requant", 64'(requant_idx_o), 64'd0);
    check("rst_last", 64'(last_tile_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_cfg_err", 64'(cfg_err_o), 64'd0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    // Attention, one head, lin=2 attn=3, no backpressure: 14 descriptors
    layer_i = 1'b0; n_heads_i = 3'd1; lin_tiles_i = 2; attn_tiles_i = 3;
    tile_ready_i = 1'b1;
    push_attn(1, 2, 3);
    run_seq("attn1", 1'b0);

    // Attention, two heads, lin=1 attn=1, ready toggling: 12 handshakes
    @(posedge clk_i);
    #1;
    n_heads_i = 3'd2; lin_tiles_i = 1; attn_tiles_i = 1;
    tile_ready_i = 1'b1;
    push_attn(2, 1, 1);
    run_seq("attn2", 1'b1);

    // Feedforward, lin=3: n_heads and attn_tiles are ignored
    @(posedge clk_i);
    #1;
    layer_i = 1'b1; n_heads_i = 3'd0; lin_tiles_i = 3; attn_tiles_i = 0;
    tile_ready_i = 1'b1;
    push_ff(3);
    run_seq("ff", 1'b0);

    // Illegal configurations
    @(posedge clk_i);
    #1;
    layer_i = 1'b0; n_heads_i = 3'd1; lin_tiles_i = 0; attn_tiles_i = 1;
    cfg_reject("cfg_lin0");
    n_heads_i = 3'(H + 1); lin_tiles_i = 1; attn_tiles_i = 1;
    cfg_reject("cfg_heads");

    // Start while busy is ignored; inputs changed during RUN do not disturb the sequence
    layer_i = 1'b0; n_heads_i = 3'd1; lin_tiles_i = 1; attn_tiles_i = 1;
    tile_ready_i = 1'b0;
    push_attn(1, 1, 1);
    pulse_start();
    @(negedge clk_i);
    check("run_busy", 64'(busy_o), 64'd1);
    lin_tiles_i = 0; layer_i = 1'b1; n_heads_i = 3'd5;
    pulse_start();
    @(negedge clk_i);
    check("run_restart_no_err", 64'(cfg_err_o), 64'd0);
    check("run_restart_busy", 64'(busy_o), 64'd1);
    check("run_restart_step", 64'(step_o), 64'd1);
    layer_i = 1'b0; n_heads_i = 3'd1; lin_tiles_i = 7; attn_tiles_i = 7;
    @(posedge clk_i);
    #1;
    pulse_start();
    @(negedge clk_i);
    check("run_restart2_no_err", 64'(cfg_err_o), 64'd0);
    check("run_restart2_tile", 64'(tile_o), 64'd0);
    @(posedge clk_i);
    #1;
    tile_ready_i = 1'b1;
    wait_done(100, 1'b0, seen);
    check("run_done_seen", 64'(seen), 64'd1);
    check("run_queue_empty", 64'(exp_q.size()), 64'd0);
    exp_q.delete();

    // Soft abort while the 5th descriptor (V0) is presented, then immediate restart
    @(posedge clk_i);
    #1;
    layer_i = 1'b0; n_heads_i = 3'd1; lin_tiles_i = 2; attn_tiles_i = 3;
    tile_ready_i = 1'b1;
    exp_q.push_back(mk(1, 0, 0, 0, 0));
    exp_q.push_back(mk(1, 0, 1, 0, 1));
    exp_q.push_back(mk(2, 0, 0, 1, 0));
    exp_q.push_back(mk(2, 0, 1, 1, 1));
    d0 = done_cnt;
    pulse_start();
    repeat (4) @(posedge clk_i);
    #1;
    tile_ready_i = 1'b0;
    clear_i = 1'b1;
    @(negedge clk_i);
    check("clr_fifth_step", 64'(step_o), 64'd3);
    @(posedge clk_i);
    #1;
    clear_i = 1'b0;
    tile_ready_i = 1'b1;
    push_attn(1, 2, 3);
    start_i = 1'b1;
    @(negedge clk_i);
    check("clr_valid", 64'(tile_valid_o), 64'd0);
    check("clr_busy", 64'(busy_o), 64'd0);
    check("clr_step", 64'(step_o), 64'd0);
    check("clr_tile", 64'(tile_o), 64'd0);
    check("clr_done", 64'(done_o), 64'd0);
    check("clr_queue", 64'(exp_q.size()), 64'd14);
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    @(negedge clk_i);
    check("restart_valid", 64'(tile_valid_o), 64'd1);
    check("restart_step", 64'(step_o), 64'd1);
    check("restart_head", 64'(head_o), 64'd0);
    check("restart_tile", 64'(tile_o), 64'd0);
    wait_done(100, 1'b0, seen);
    check("restart_done_seen", 64'(seen), 64'd1);
    check("restart_queue_empty", 64'(exp_q.size()), 64'd0);
    @(negedge clk_i);
    check("clr_done_count", 64'(done_cnt - d0), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
